delayed_subtractor: RTL and testbench

Pipelined inverse of the delayed adder. It takes a 5-bit sum and one 4-bit operand, recovers the other 4-bit operand (`a = sum - b`) and flags results that do not fit in 4 bits. The result emerges after a fixed, parameterised number of clock cycles. It sits downstream of the adder datapath, where it undoes or checks additions, and uses a valid/ready handshake on both sides so it can be back-pressured.

---
 rtl/delayed_arith_pkg.sv | 20 ++
 rtl/sub_range_calc.sv | 37 +++
 rtl/delayed_subtractor.sv | 68 ++++++
 tb/tb_delayed_subtractor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delayed_arith_pkg.sv
// Shared constants and stage payload type for the delayed adder/subtractor datapath.
// Build option: DELAYED_SUB_SAT_EN selects saturating results in sub_range_calc.
package delayed_arith_pkg;

    // Operand, sum and signed difference widths
    localparam int OPERAND_W = 4;
    localparam int SUM_W     = 5;
    localparam int DIFF_W    = 6;

    // Deepest pipeline the subtractor is meant to be built with
    localparam int DELAY_MAX = 8;

    // Contents of one pipeline stage: valid flag plus the result it carries
    typedef struct packed {
        logic                 valid;
        logic [OPERAND_W-1:0] a;
        logic                 range_err;
    } stage_t;

endpackage

// File: rtl/sub_range_calc.sv
// Combinational core of the delayed subtractor: recovers a = sum - b and flags
// results outside 0..15.
// Build option: DELAYED_SUB_SAT_EN clamps out-of-range results to 0 / 15 instead
// of letting them wrap; range_err asserts in both builds.
module sub_range_calc
    import delayed_arith_pkg::*;
(
    input  logic [SUM_W-1:0]     sum,
    input  logic [OPERAND_W-1:0] b,
    output logic [OPERAND_W-1:0] a,
    output logic                 range_err
);

    logic [DIFF_W-1:0] diff;
    logic              underflow;
    logic              overflow;

    // Subtract in a 6-bit two's complement space so both underflow and overflow are visible
    always_comb begin
        diff      = {1'b0, sum} - {2'b00, b};
        underflow = diff[DIFF_W-1];
        overflow  = !diff[DIFF_W-1] && diff[SUM_W-1];
        range_err = underflow || overflow;
`ifdef DELAYED_SUB_SAT_EN
        if (underflow) begin
            a = '0;
        end else if (overflow) begin
            a = '1;
        end else begin
            a = diff[OPERAND_W-1:0];
        end
`else
        a = diff[OPERAND_W-1:0];
`endif
    end

endmodule

// File: rtl/delayed_subtractor.sv
// Fixed-latency pipelined subtractor (inverse of the delayed adder).
// Accepts {sum, b} with a valid/ready handshake, delivers a = sum - b and a
// range flag DELAY cycles later. Back-pressure freezes the whole pipeline;
// bubbles travel as invalid stages and are never collapsed.
// Build option: DELAYED_SUB_SAT_EN (saturating results, see sub_range_calc).
// DELAY is expected to lie in 1..DELAY_MAX.
module delayed_subtractor
    import delayed_arith_pkg::*;
#(
    parameter int DELAY = 2
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SUM_W-1:0]     sum,
    input  logic [OPERAND_W-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] a,
    output logic                 range_err
);

    stage_t               stages [DELAY];
    logic [OPERAND_W-1:0] calc_a;
    logic                 calc_err;
    logic                 stall;

    sub_range_calc u_calc (
        .sum       (sum),
        .b         (b),
        .a         (calc_a),
        .range_err (calc_err)
    );

    // The last stage is the output; a stall happens only when it is full and not taken
    always_comb begin
        out_valid = stages[DELAY-1].valid;
        a         = stages[DELAY-1].a;
        range_err = stages[DELAY-1].range_err;
        stall     = stages[DELAY-1].valid && !out_ready;
        in_ready  = !stall;
    end

    // Advance all stages together unless stalled; payload only moves with a valid bit so idle outputs keep their last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                stages[i] <= '0;
            end
        end else if (!stall) begin
            stages[0].valid <= in_valid;
            if (in_valid) begin
                stages[0].a         <= calc_a;
                stages[0].range_err <= calc_err;
            end
            for (int i = 1; i < DELAY; i++) begin
                stages[i].valid <= stages[i-1].valid;
                if (stages[i-1].valid) begin
                    stages[i].a         <= stages[i-1].a;
                    stages[i].range_err <= stages[i-1].range_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_delayed_subtractor.sv
// Scoreboard bench for delayed_subtractor (DELAY = 2), plus DELAY = 1 and
// DELAY = 8 instances for the latency sweep.
// Build option: DELAYED_SUB_SAT_EN changes the expected out-of-range results.
module tb_delayed_subtractor;

    localparam int DELAY = 2;

    typedef struct {
        logic [3:0] a;
        logic       err;
        int         in_edge;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] sum;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] a;
    logic       range_err;

    logic       lat_valid;
    logic       l1_ready, l1_valid, l1_err;
    logic [3:0] l1_a;
    logic       l8_ready, l8_valid, l8_err;
    logic [3:0] l8_a;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_stall = -1;
    int         stall_left = 0;
    bit         random_bp = 0;
    logic [3:0] last_a = 4'd0;
    logic       last_err = 1'b0;

    delayed_subtractor #(.DELAY(DELAY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .range_err(range_err)
    );

    delayed_subtractor #(.DELAY(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(lat_valid), .in_ready(l1_ready),
        .sum(sum), .b(b), .out_valid(l1_valid), .out_ready(1'b1),
        .a(l1_a), .range_err(l1_err)
    );

    delayed_subtractor #(.DELAY(8)) dut_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(lat_valid), .in_ready(l8_ready),
        .sum(sum), .b(b), .out_valid(l8_valid), .out_ready(1'b1),
        .a(l8_a), .range_err(l8_err)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to time-stamp transfers
    always @(posedge clk) cyc++;

    // Reference: plain integer subtraction, then wrap or clamp
    function automatic exp_t model(input int s, input int bb, input int e);
        exp_t r;
        int   d;
        d = s - bb;
        r.err = (d < 0) || (d > 15);
`ifdef DELAYED_SUB_SAT_EN
        r.a = (d < 0) ? 4'd0 : (d > 15) ? 4'd15 : 4'(d);
`else
        r.a = 4'(((d % 16) + 16) % 16);
`endif
        r.in_edge = e;
        return r;
    endfunction

    task automatic check_output(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Downstream: optional random back-pressure, plus an armed stall of N cycles once data shows up
    always @(negedge clk) begin
        if (stall_left > 0 && out_valid) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (random_bp) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: ready rule every cycle, presented data against the queue head, pop on transfer
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            check_output("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid) begin
                if (!out_ready) last_stall = cyc;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_output: got a=%0d expected no output (cycle %0d)", a, cyc);
                end else begin
                    check_output("a", int'(a), int'(q[0].a));
                    check_output("range_err", int'(range_err), int'(q[0].err));
                    if (out_ready) begin
                        if (last_stall < q[0].in_edge)
                            check_output("latency", cyc - q[0].in_edge + 1, DELAY);
                        void'(q.pop_front());
                    end
                end
                last_a   = a;
                last_err = range_err;
            end else begin
                check_output("idle_hold_a", int'(a), int'(last_a));
                check_output("idle_hold_err", int'(range_err), int'(last_err));
            end
        end
    end

    // Present one input and hold it until accepted, recording the expected result
    task automatic apply_stimulus(input int s, input int bb);
        bit done;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            sum      = 5'(s);
            b        = 4'(bb);
            #1;
            if (in_ready) begin
                q.push_back(model(s, bb, cyc + 1));
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check_output("drain_left", q.size(), 0);
    endtask

    // Two back-to-back inputs into DELAY=1 and DELAY=8 copies; measure latency and results
    task automatic latency_sweep();
        int         e0;
        int         c1[$], c8[$];
        logic [3:0] v1[$], v8[$];
        exp_t       m0, m1;
        m0 = model(7, 3, 0);
        m1 = model(8, 3, 0);
        fork
            begin
                @(negedge clk);
                lat_valid = 1'b1;
                sum = 5'd7;
                b   = 4'd3;
                e0  = cyc + 1;
                @(negedge clk);
                sum = 5'd8;
                @(negedge clk);
                lat_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    #1;
                    if (l1_valid) begin c1.push_back(cyc); v1.push_back(l1_a); end
                    if (l8_valid) begin c8.push_back(cyc); v8.push_back(l8_a); end
                end
            end
        join
        check_output("d1_count", c1.size(), 2);
        check_output("d8_count", c8.size(), 2);
        if (c1.size() == 2) begin
            check_output("d1_latency", c1[0] - e0 + 1, 1);
            check_output("d1_back_to_back", c1[1] - c1[0], 1);
            check_output("d1_a0", int'(v1[0]), int'(m0.a));
            check_output("d1_a1", int'(v1[1]), int'(m1.a));
        end
        if (c8.size() == 2) begin
            check_output("d8_latency", c8[0] - e0 + 1, 8);
            check_output("d8_back_to_back", c8[1] - c8[0], 1);
            check_output("d8_a0", int'(v8[0]), int'(m0.a));
            check_output("d8_a1", int'(v8[1]), int'(m1.a));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        lat_valid = 1'b0;
        sum       = '0;
        b         = '0;
        out_ready = 1'b1;
        #1;
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_a", int'(a), 0);
        check_output("reset_range_err", int'(range_err), 0);
        check_output("reset_in_ready", int'(in_ready), 1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic and range cases");
        apply_stimulus(7, 3);
        apply_stimulus(8, 3);
        idle(1);
        wait_drain();
        apply_stimulus(2, 5);
        apply_stimulus(20, 0);
        apply_stimulus(31, 15);
        apply_stimulus(0, 0);
        idle(1);
        wait_drain();

        $display("[TB] back-pressure stream");
        stall_left = 3;
        for (int s = 10; s <= 13; s++) apply_stimulus(s, 1);
        idle(1);
        wait_drain();

        $display("[TB] reset mid-flight");
        apply_stimulus(9, 2);
        apply_stimulus(12, 2);
        @(posedge clk);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_output("midreset_out_valid", int'(out_valid), 0);
        check_output("midreset_a", int'(a), 0);
        check_output("midreset_range_err", int'(range_err), 0);
        check_output("midreset_in_ready", int'(in_ready), 1);
        q.delete();
        last_a   = 4'd0;
        last_err = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        apply_stimulus(15, 15);
        idle(1);
        wait_drain();

        $display("[TB] random traffic");
        random_bp = 1;
        for (int i = 0; i < 80; i++) begin
            apply_stimulus(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(1);
        random_bp = 0;
        wait_drain();

        $display("[TB] latency sweep");
        latency_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
